// File: rtl/spwm_deadtime_gate.sv
// SPWM comparator and complementary gate driver with guaranteed dead time.
// Reference samples are double-buffered and only take effect at the carrier wrap.
module spwm_deadtime_gate #(
    parameter int WIDTH    = 10,
    parameter int DEADTIME = 8,
    parameter int DT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] carrier,
    input  logic signed [WIDTH-1:0] ref_in,
    input  logic                    ref_valid,
    output logic                    ref_ready,
    output logic                    gate_hi,
    output logic                    gate_lo,
    output logic                    stale
);

    typedef enum logic [2:0] {
        IDLE,
        HI_ON,
        DT_TO_LO,
        LO_ON,
        DT_TO_HI
    } state_e;

    localparam logic signed [WIDTH-1:0] CARRIER_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [DT_W-1:0]         DT_LOAD     = DT_W'(DEADTIME - 1);

    logic signed [WIDTH-1:0] shadow_q, shadow_d;
    logic signed [WIDTH-1:0] ref_active_q, ref_active_d;
    logic                    shadow_full_q, shadow_full_d;
    logic                    stale_q, stale_d;
    logic                    demand_q, demand_d;

    state_e                  state_q;
    logic [DT_W-1:0]         dt_cnt_q;
    logic                    gate_hi_q, gate_lo_q;

    logic                    wrap;
    logic                    accept;

    assign wrap   = (carrier == CARRIER_MAX);
    assign accept = ref_valid && !shadow_full_q;

    // NOTE: every _d gets its default first so this block can never infer a latch.
    always_comb begin
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        ref_active_d  = ref_active_q;
        stale_d       = 1'b0;

        if (wrap && shadow_full_q) begin
            ref_active_d  = shadow_q;
            shadow_full_d = 1'b0;
        end else begin
            // Wrap with nothing pending: hold the duty, but a same-cycle sample still lands in the shadow.
            stale_d = wrap;
            if (accept) begin
                shadow_d      = ref_in;
                shadow_full_d = 1'b1;
            end
        end
    end

    assign demand_d = (ref_active_q > carrier);

    // NOTE: clocked blocks use non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_active_q  <= '0;
            shadow_full_q <= 1'b0;
            stale_q       <= 1'b0;
            demand_q      <= 1'b0;
        end else begin
            ref_active_q  <= ref_active_d;
            shadow_full_q <= shadow_full_d;
            stale_q       <= stale_d;
            demand_q      <= demand_d;
        end
    end

    // NOTE: shadow data has no reset; shadow_full_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    // Gate registers are written together with the state so they always equal its decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dt_cnt_q  <= '0;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else if (!en) begin
            state_q   <= IDLE;
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
        end else begin
            gate_hi_q <= 1'b0;
            gate_lo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    state_q  <= demand_q ? DT_TO_HI : DT_TO_LO;
                    dt_cnt_q <= DT_LOAD;
                end
                HI_ON: begin
                    if (!demand_q) begin
                        state_q  <= DT_TO_LO;
                        dt_cnt_q <= DT_LOAD;
                    end else begin
                        gate_hi_q <= 1'b1;
                    end
                end
                LO_ON: begin
                    if (demand_q) begin
                        state_q  <= DT_TO_HI;
                        dt_cnt_q <= DT_LOAD;
                    end else begin
                        gate_lo_q <= 1'b1;
                    end
                end
                DT_TO_LO, DT_TO_HI: begin
                    // The count always runs out before either gate turns on, whatever demand does meanwhile.
                    if (dt_cnt_q == '0) begin
                        if (demand_q) begin
                            state_q   <= HI_ON;
                            gate_hi_q <= 1'b1;
                        end else begin
                            state_q   <= LO_ON;
                            gate_lo_q <= 1'b1;
                        end
                    end else begin
                        dt_cnt_q <= dt_cnt_q - DT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ref_ready = !shadow_full_q;
    assign gate_hi   = gate_hi_q;
    assign gate_lo   = gate_lo_q;
    assign stale     = stale_q;

endmodule
